// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the shared SRAM.
// master: the arbiter's view; slave: the CPU + memory environment's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              cpu_stall;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           cpu_stall
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
           cpu_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: serialises CPU fetch and data accesses onto one req/ack port.
// Define ARB_FAIR_EN to let a waiting fetch win after STARVE_MAX consecutive DM grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              dm_pend_c;
  logic              if_first_c;

  // A limit beyond the counter range could never trigger.
  if (STARVE_MAX >= (32'd1 << CNT_W)) begin : g_starve_range
    $error("STARVE_MAX does not fit the starvation counter");
  end

  // Read+write together is illegal and is served as a write.
  assign dm_pend_c = bus.dm_read | bus.dm_write;

`ifdef ARB_FAIR_EN
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign if_first_c = bus.if_req & (~dm_pend_c | (starve_q == STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign if_first_c = bus.if_req & ~dm_pend_c;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  // Arbitration, memory sequencing and completion.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
`ifdef ARB_FAIR_EN
    starve_d    = starve_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef ARB_FAIR_EN
        if (!bus.if_req) starve_d = '0;
`endif
        if (if_first_c) begin
          state_d    = IF_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
`ifdef ARB_FAIR_EN
          starve_d   = '0;
`endif
        end else if (dm_pend_c) begin
          state_d     = DM_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_write;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
`ifdef ARB_FAIR_EN
          if (bus.if_req) starve_d = CNT_W'(starve_q + 1'b1);
`endif
        end
      end
      IF_ACC: begin
        if (bus.mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      DM_ACC: begin
        if (bus.mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;

  assign bus.cpu_stall = (bus.if_req & ~if_ready_q) | (dm_pend_c & ~dm_ready_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized transactions
// checked against a cycle-count and memory-contents reference model.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Memory macro model (sram) and the bench's own view of what it should hold (ref_mem).
  logic [31:0] sram    [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          tie_ack   = 1'b0;
  bit          resp_en   = 1'b1;
  int          resp_wait = 0;
  int          wait_cnt  = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after resp_wait wait states, or every cycle when tied.
  always @(posedge clk) begin
    #1;
    if (tie_ack) begin
      bus.mem_ack = 1'b1;
      wait_cnt    = 0;
    end else if (bus.mem_req && resp_en && wait_cnt == resp_wait) begin
      bus.mem_ack = 1'b1;
      wait_cnt    = 0;
    end else if (bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wait_cnt++;
    end else begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
    bus.mem_rdata = sram[bus.mem_addr[9:0]];
    if (bus.mem_ack && bus.mem_req && bus.mem_we) sram[bus.mem_addr[9:0]] = bus.mem_wdata;
  end

  // One transaction (fetch, data access, or both) started from IDLE; dm_kind 0=rd 1=wr 2=rd+wr.
  task automatic run_txn(input bit do_if, input bit do_dm, input int dm_kind, input int w,
                         input bit tie, input logic [15:0] ia, input logic [15:0] da,
                         input logic [31:0] wd);
    int exp_if, exp_dm, if_start, dm_start, last;
    bit dm_we, in_if, in_dm;
    dm_we = (dm_kind != 0);
    @(posedge clk); #1;
    tie_ack   = tie;
    resp_wait = w;
    exp_if = -1; exp_dm = -1; if_start = -1; dm_start = -1;
    if (do_dm) begin
      dm_start = 1;
      exp_dm   = 2 + w;
      if (dm_we) ref_mem[da[9:0]] = wd;
      else       exp_dm_rdata = ref_mem[da[9:0]];
    end
    if (do_if) begin
      if_start     = do_dm ? exp_dm + 2 : 1;
      exp_if       = if_start + 1 + w;
      exp_if_rdata = ref_mem[ia[9:0]];
    end
    last = (exp_if > exp_dm) ? exp_if : exp_dm;
    bus.if_req   = do_if;
    bus.if_addr  = ia;
    bus.dm_read  = do_dm && (dm_kind != 1);
    bus.dm_write = do_dm && (dm_kind != 0);
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      in_if = do_if && c >= if_start && c <= if_start + w;
      in_dm = do_dm && c >= dm_start && c <= dm_start + w;
      chk("mem_req", bus.mem_req, in_if || in_dm);
      if (in_dm) begin
        chk("dm_mem_addr", bus.mem_addr, da);
        chk("dm_mem_we", bus.mem_we, dm_we);
        if (dm_we) chk("dm_mem_wdata", bus.mem_wdata, wd);
      end
      if (in_if) begin
        chk("if_mem_addr", bus.mem_addr, ia);
        chk("if_mem_we", bus.mem_we, 1'b0);
      end
      chk("if_ready", bus.if_ready, c == exp_if);
      chk("dm_ready", bus.dm_ready, c == exp_dm);
      chk("cpu_stall", bus.cpu_stall, (do_if && c < exp_if) || (do_dm && c < exp_dm));
      if (c == exp_if) begin
        chk("if_rdata", bus.if_rdata, exp_if_rdata);
        bus.if_req = 1'b0;
      end
      if (c == exp_dm) begin
        chk("dm_rdata", bus.dm_rdata, exp_dm_rdata);
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
      end
    end
  endtask

  // Fetch held while data reads keep coming; records who got each of the first grants.
  task automatic fair_test();
    int   grants[$];
    int   starve, exp_g, obs_g;
    bit   prev, if_done, dm_done, if_wait;
    @(posedge clk); #1;
    tie_ack = 1'b0; resp_wait = 0;
    bus.if_req  = 1'b1; bus.if_addr = 16'h0044;
    bus.dm_read = 1'b1; bus.dm_write = 1'b0; bus.dm_addr = 16'h0088;
    prev = 1'b0; if_done = 1'b0; dm_done = 1'b0;
    for (int c = 0; c < 80 && !(if_done && dm_done); c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev) grants.push_back((bus.mem_addr == 16'h0044) ? 1 : 0);
      prev = bus.mem_req;
      if (bus.if_ready && !if_done) begin
        chk("fair_if_rdata", bus.if_rdata, ref_mem[10'h044]);
        bus.if_req = 1'b0;
        if_done    = 1'b1;
      end
      if (bus.dm_ready) begin
        chk("fair_dm_rdata", bus.dm_rdata, ref_mem[10'h088]);
        if (grants.size() >= 6) begin
          bus.dm_read = 1'b0;
          dm_done     = 1'b1;
        end
      end
    end
    chk("fair_completed", {if_done, dm_done}, 2'b11);
    exp_dm_rdata = ref_mem[10'h088];
    exp_if_rdata = ref_mem[10'h044];
    starve  = 0;
    if_wait = 1'b1;
    for (int g = 0; g < 6; g++) begin
`ifdef ARB_FAIR_EN
      exp_g = (if_wait && starve == int'(STARVE_MAX)) ? 1 : 0;
`else
      exp_g = 0;
`endif
      if (exp_g == 1) begin
        if_wait = 1'b0;
        starve  = 0;
      end else if (if_wait) begin
        starve++;
      end
      obs_g = (g < grants.size()) ? grants[g] : 2;
      chk($sformatf("fair_grant%0d_is_if", g), obs_g, exp_g);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int          kind, w, dk;
    logic [15:0] ia, da;
    logic [31:0] wd;

    for (int i = 0; i < 1024; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[10'h010]    = 32'hDEADBEEF;
    ref_mem[10'h010] = 32'hDEADBEEF;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset values.
    #2;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_dm_ready", bus.dm_ready, 1'b0);
    chk("rst_cpu_stall_idle", bus.cpu_stall, 1'b0);
    bus.if_req = 1'b1;
    #1;
    chk("rst_cpu_stall_req", bus.cpu_stall, 1'b1);
    bus.if_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Fetch with ack tied high.
    run_txn(1'b1, 1'b0, 0, 0, 1'b1, 16'h0010, 16'h0000, 32'h0);
    chk("tp1_if_rdata", bus.if_rdata, 32'hDEADBEEF);

    // Store with two wait states.
    run_txn(1'b0, 1'b1, 1, 2, 1'b0, 16'h0000, 16'h0200, 32'h12345678);
    chk("tp2_sram_written", sram[10'h200], 32'h12345678);
    chk("tp2_dm_rdata_kept", bus.dm_rdata, 32'h0);

    // Fetch and load together: DM first.
    run_txn(1'b1, 1'b1, 0, 0, 1'b0, 16'h0020, 16'h0030, 32'h0);

    fair_test();

    // Reset in the middle of a data access.
    @(posedge clk); #1;
    tie_ack = 1'b0; resp_en = 1'b0;
    bus.dm_read = 1'b1; bus.dm_addr = 16'h0100;
    @(negedge clk);
    chk("rstmid_c0_req", bus.mem_req, 1'b0);
    @(negedge clk);
    chk("rstmid_c1_req", bus.mem_req, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rstmid_req_drop", bus.mem_req, 1'b0);
    chk("rstmid_dm_ready", bus.dm_ready, 1'b0);
    chk("rstmid_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rstmid_if_rdata", bus.if_rdata, 32'h0);
    chk("rstmid_mem_addr", bus.mem_addr, 16'h0);
    bus.dm_read  = 1'b0;
    exp_dm_rdata = '0;
    exp_if_rdata = '0;
    @(negedge clk);
    rst = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstpost_dm_ready", bus.dm_ready, 1'b0);
      chk("rstpost_mem_req", bus.mem_req, 1'b0);
    end
    run_txn(1'b0, 1'b1, 0, 1, 1'b0, 16'h0000, 16'h0100, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      w    = $urandom_range(0, 3);
      dk   = $urandom_range(0, 1);
      ia   = 16'($urandom_range(0, 63));
      da   = 16'($urandom_range(0, 63));
      wd   = $urandom;
      case (kind)
        0:       run_txn(1'b1, 1'b0, 0, w, 1'b0, ia, da, wd);
        1:       run_txn(1'b0, 1'b1, 0, w, 1'b0, ia, da, wd);
        2:       run_txn(1'b0, 1'b1, 1, w, 1'b0, ia, da, wd);
        3:       run_txn(1'b0, 1'b1, 2, w, 1'b0, ia, da, wd);
        default: run_txn(1'b1, 1'b1, dk, w, 1'b0, ia, da, wd);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer sharing one unified instruction/data SRAM between the CPU fetch port (`pc_output`/`IM_out`) and data port (`mem_DM_read`/`mem_DM_write`/`mem_alu_result`/`mem_sw_o`/`DM_out`). It sits between the pipelined CPU and the memory macro. It grants one access at a time and drives the memory with a req/ack handshake. It returns data and a one-cycle ready pulse to the winning requester and raises `cpu_stall` while any CPU access is outstanding.

## Interface
- `ADDR_W`, 16, word address width on all ports
- `DATA_W`, 32, data width (matches `RegBus`)
- `STARVE_MAX`, 4, consecutive DM grants allowed while IF waits (used only with `ARB_FAIR_EN`)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word, valid with `if_ready`
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `dm_read`  in  1  data read request, held until `dm_ready`
- `dm_write`  in  1  data write request, held until `dm_ready`
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  load data, valid with `dm_ready`
- `dm_ready`  out  1  one-cycle completion pulse for data access
- `mem_req`  out  1  memory access request, held until `mem_ack`
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid in the `mem_ack` cycle
- `mem_ack`  in  1  memory completion (0..n wait states)
- `cpu_stall`  out  1  combinational: `(if_req & ~if_ready) | ((dm_read|dm_write) & ~dm_ready)`

## Operation
- FSM states: IDLE, IF_ACC, DM_ACC, DONE.
- IDLE: arbitrate among pending requests. DM wins over IF by default, because the DM access belongs to the older instruction. Winning request goes to IF_ACC or DM_ACC. The address, write data and `mem_we` are latched into output registers and `mem_req` is set.
- `dm_read` and `dm_write` both high is illegal. The arbiter treats it as a write.
- IF_ACC/DM_ACC: hold `mem_req` and the latched fields. On `mem_ack`:
  - clear `mem_req`
  - capture `mem_rdata` into `if_rdata` or `dm_rdata` (reads only; writes leave `dm_rdata` unchanged)
  - go to DONE
- DONE: pulse `if_ready` or `dm_ready` for exactly one cycle, then return to IDLE.
- A requester must hold its request until ready. The request is deasserted in the DONE cycle or later, and is ignored in IDLE if it is already low.
- A request present in IDLE on the cycle after DONE is arbitrated immediately, giving back-to-back accesses.
- `if_rdata`/`dm_rdata` hold their value until the next capture.
- A `mem_ack` outside IF_ACC/DM_ACC is ignored.

## Timing
- Reset (`rst`=0, async): state IDLE, all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, `if_ready`, `dm_ready`), starvation counter 0. `cpu_stall` follows its equation.
- Reset mid-access aborts immediately: `mem_req` drops asynchronously and no ready pulse is issued.
- Latency, with the request first seen in IDLE at cycle 0:
  - `mem_req` high from cycle 1
  - zero-wait `mem_ack` at cycle 1
  - ready pulse at cycle 2
  - each memory wait state adds one cycle
- Throughput: one access per 3 cycles at zero wait.
- Simultaneous IF and DM in IDLE: DM at cycles 0–2, IF arbitrated at cycle 3, IF ready at cycle 5.

## Configuration
- `ARB_FAIR_EN` defined: a 3-bit starvation counter tracks waiting fetches.
  - Increments on each DM grant while `if_req` is high.
  - Clears on an IF grant or whenever `if_req` is low in IDLE.
  - When the counter equals `STARVE_MAX` and both requests are pending in IDLE, IF wins and the counter clears.
- `ARB_FAIR_EN` undefined: strict DM priority. The counter logic is absent.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x0010, `mem_ack` tied high:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=0x0010 at cycle 1
  - `if_ready`=1 with `if_rdata`=0xDEADBEEF at cycle 2
  - `cpu_stall` high during cycles 0–1
- `dm_write` with `dm_addr`=0x0200, `dm_wdata`=0x12345678, memory inserting 2 wait states:
  - `mem_we`=1, fields held for cycles 1–3
  - `dm_ready` at cycle 4
  - `dm_rdata` unchanged
- `if_req` and `dm_read` asserted together: DM is served first (`dm_ready` at cycle 2), IF second (`if_ready` at cycle 5).
- With `ARB_FAIR_EN`: `if_req` held while `dm_read` is re-requested continuously. After 4 DM grants, the 5th grant goes to IF; a DM grant follows.
- Without `ARB_FAIR_EN`, same stimulus: IF is never granted while DM is continuous.
- `rst` pulled low during DM_ACC with `mem_ack`=0: `mem_req` drops the same cycle. After release: IDLE, no `dm_ready`, and a re-issued request completes normally.
